// File: rtl/fp_dot_accum.sv
// fp_dot_accum: accumulates N_TERMS signed fixed-point products plus a bias into one
// saturated fixed-point result. Valid/ready handshakes on both the product and result sides.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous abort of the partial sum (a held result is kept)
//   prod_valid  product beat valid
//   prod_ready  product beat accepted this cycle
//   prod        signed product (same Q format as sum)
//   bias        signed offset, sampled only with term 0
//   sum_valid   result valid
//   sum_ready   downstream accepts the result
//   sum         signed saturated result
//   sum_sat     result was clipped to max/min
//   busy        partial sum in progress (term count != 0)
module fp_dot_accum #(
  parameter int unsigned fp_width   = 16,
  parameter int unsigned fp_frac    = 8,
  parameter int unsigned N_TERMS    = 3,
  parameter int unsigned GUARD_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                prod_valid,
  output logic                prod_ready,
  input  logic [fp_width-1:0] prod,
  input  logic [fp_width-1:0] bias,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic [fp_width-1:0] sum,
  output logic                sum_sat,
  output logic                busy
);

  localparam int unsigned AccW = fp_width + GUARD_BITS;
  localparam int unsigned CntW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  // Parameter sanity checks, evaluated at elaboration only.
  if (fp_frac >= fp_width) begin : gen_bad_frac
    $error("fp_frac must be smaller than fp_width");
  end
  if (N_TERMS < 1 || (1 << GUARD_BITS) < N_TERMS + 1) begin : gen_bad_guard
    $error("GUARD_BITS too small for N_TERMS");
  end

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                     state_q, state_d;
  logic signed [AccW-1:0]     acc_q, acc_d;
  logic        [CntW-1:0]     cnt_q, cnt_d;
  logic        [fp_width-1:0] sum_q, sum_d;
  logic                       sum_sat_q, sum_sat_d;
  logic                       sum_valid_q, sum_valid_d;

  logic signed [AccW-1:0]     prod_ext, bias_ext, acc_base, acc_next;
  logic                       accept, sum_take, last_term, pos_ovf, neg_ovf;
  logic        [fp_width-1:0] sat_val;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign prod_ext  = {{GUARD_BITS{prod[fp_width-1]}}, prod};
  assign bias_ext  = {{GUARD_BITS{bias[fp_width-1]}}, bias};
  // Term 0 starts from the bias, later terms from the running sum.
  assign acc_base  = (cnt_q == '0) ? bias_ext : acc_q;
  assign acc_next  = acc_base + prod_ext;
  assign last_term = (cnt_q == CntW'(N_TERMS - 1));

  assign accept    = prod_valid && prod_ready && !flush;
  assign sum_take  = sum_valid_q && sum_ready;

  // Out of range when the guard bits plus the result MSB are not all equal.
  assign pos_ovf   = !acc_next[AccW-1] && (|acc_next[AccW-2:fp_width-1]);
  assign neg_ovf   = acc_next[AccW-1] && !(&acc_next[AccW-2:fp_width-1]);

  always_comb begin
    sat_val = acc_next[fp_width-1:0];
    if (pos_ovf) begin
      sat_val = {1'b0, {(fp_width-1){1'b1}}};
    end else if (neg_ovf) begin
      sat_val = {1'b1, {(fp_width-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (sum_take) begin
      state_d = StIdle;
    end
    if (flush) begin
      // A held result survives a flush; only the partial sum is dropped.
      if (state_q != StHold) begin
        state_d = StIdle;
      end
    end else if (accept) begin
      state_d = last_term ? StHold : StAccum;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Gated by rst_n so every output reads 0 while reset is asserted.
    prod_ready = rst_n && ((state_q != StHold) || sum_ready);
    busy       = (cnt_q != '0);
    sum_valid  = sum_valid_q;
    sum        = sum_q;
    sum_sat    = sum_sat_q;
  end

  // ---------------------------------------------------------------------------
  // Accumulator, counter and result registers
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sum_sat_d   = sum_sat_q;
    sum_valid_d = sum_valid_q;
    if (sum_take) begin
      sum_valid_d = 1'b0;
    end
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last_term) begin
        // Finalize on the same edge as the last accept.
        acc_d       = '0;
        cnt_d       = '0;
        sum_d       = sat_val;
        sum_sat_d   = pos_ovf || neg_ovf;
        sum_valid_d = 1'b1;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_sat_q   <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sum_sat_q   <= sum_sat_d;
      sum_valid_q <= sum_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_dot_accum.sv
// Self-checking bench for fp_dot_accum (defaults: Q7.8, three terms).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fp_dot_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] prod;
  logic [15:0] bias;
  logic        sum_valid;
  logic        sum_ready;
  logic [15:0] sum;
  logic        sum_sat;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_dot_accum #(
    .fp_width  (16),
    .fp_frac   (8),
    .N_TERMS   (3),
    .GUARD_BITS(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .prod      (prod),
    .bias      (bias),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum       (sum),
    .sum_sat   (sum_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bias;
    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] want_sum;
    logic        want_sat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat (called at posedge+1) and confirm it is accepted on the next edge.
  task automatic beat(input logic [15:0] b, input logic [15:0] p, input string tag);
    prod_valid = 1'b1;
    bias       = b;
    prod       = p;
    @(negedge clk);
    check({tag, " prod_ready"}, 32'(prod_ready), 32'd1);
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " sum_valid"}, 32'(sum_valid), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'd0);
    check({tag, " sum_sat"}, 32'(sum_sat), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " prod_ready"}, 32'(prod_ready), 32'd0);
  endtask

  // One dot product with sum_ready=1; bias on non-zero terms is random junk.
  task automatic run_dot(input vec_t v, input string tag);
    sum_ready = 1'b1;
    beat(v.bias, v.p0, tag);
    beat(16'($urandom), v.p1, tag);
    prod_valid = 1'b1;
    bias       = 16'($urandom);
    prod       = v.p2;
    @(negedge clk);
    check({tag, " early sum_valid"}, 32'(sum_valid), 32'd0);
    check({tag, " mid busy"}, 32'(busy), 32'd1);
    check({tag, " last prod_ready"}, 32'(prod_ready), 32'd1);
    step();
    prod_valid = 1'b0;
    @(negedge clk);
    check({tag, " sum_valid"}, 32'(sum_valid), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(v.want_sum));
    check({tag, " sum_sat"}, 32'(sum_sat), 32'(v.want_sat));
    check({tag, " busy after"}, 32'(busy), 32'd0);
    step();
    @(negedge clk);
    check({tag, " sum_valid drop"}, 32'(sum_valid), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //              bias      p0        p1        p2        sum       sat
    vecs[0] = '{16'h0010, 16'h0100, 16'h0080, 16'hFF80, 16'h0110, 1'b0};
    vecs[1] = '{16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 1'b1};
    vecs[2] = '{16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h8000, 1'b1};
    vecs[3] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b0};
    vecs[4] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b0};
    vecs[5] = '{16'h0001, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b1};
    vecs[7] = '{16'h0000, 16'hFF00, 16'hFF00, 16'h0100, 16'hFF00, 1'b0};
    // Intermediate sum leaves the 16-bit range but the final value is back inside.
    vecs[8] = '{16'h7000, 16'h7000, 16'h9000, 16'h9000, 16'h0000, 1'b0};

    rst_n      = 1'b0;
    flush      = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    bias       = '0;
    sum_ready  = 1'b1;
    #3;
    check_zero("reset");
    #10 rst_n = 1'b1;
    step();
    @(negedge clk);
    check("post-reset prod_ready", 32'(prod_ready), 32'd1);
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset sum_valid", 32'(sum_valid), 32'd0);
    step();

    // Table-driven dot products.
    for (int i = 0; i < 9; i++) begin
      run_dot(vecs[i], $sformatf("vec%0d", i));
    end

    // Result held while downstream stalls, then zero-bubble hand-over.
    sum_ready = 1'b0;
    beat(16'h0010, 16'h0100, "hold");
    beat(16'h0000, 16'h0100, "hold");
    beat(16'h0000, 16'h0100, "hold");
    prod_valid = 1'b1;
    prod       = 16'h0200;
    bias       = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d sum_valid", c), 32'(sum_valid), 32'd1);
      check($sformatf("hold%0d sum", c), 32'(sum), 32'h0310);
      check($sformatf("hold%0d prod_ready", c), 32'(prod_ready), 32'd0);
      step();
    end
    sum_ready = 1'b1;
    bias      = 16'h0005;
    @(negedge clk);
    check("handover prod_ready", 32'(prod_ready), 32'd1);
    step();
    prod = 16'h0001;
    bias = 16'h1234;
    @(negedge clk);
    check("handover sum_valid", 32'(sum_valid), 32'd0);
    check("handover busy", 32'(busy), 32'd1);
    step();
    prod = 16'h0002;
    @(negedge clk);
    check("handover t2 prod_ready", 32'(prod_ready), 32'd1);
    step();
    prod_valid = 1'b0;
    @(negedge clk);
    check("handover sum_valid", 32'(sum_valid), 32'd1);
    check("handover sum", 32'(sum), 32'h0208);
    step();

    // Gap between terms: partial sum holds, busy stays high.
    beat(16'h0000, 16'h0100, "gap");
    beat(16'h0000, 16'h0100, "gap");
    prod_valid = 1'b0;
    prod       = 16'h7777;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("gap%0d busy", c), 32'(busy), 32'd1);
      check($sformatf("gap%0d sum_valid", c), 32'(sum_valid), 32'd0);
      step();
    end
    beat(16'h0000, 16'h0100, "gap");
    prod_valid = 1'b0;
    @(negedge clk);
    check("gap sum_valid", 32'(sum_valid), 32'd1);
    check("gap sum", 32'(sum), 32'h0300);
    step();
    step();

    // Flush drops the partial sum and the beat offered with it.
    beat(16'h1000, 16'h1000, "flush");
    beat(16'h0000, 16'h1000, "flush");
    flush      = 1'b1;
    prod_valid = 1'b1;
    prod       = 16'h2000;
    step();
    flush      = 1'b0;
    prod_valid = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy), 32'd0);
    check("flush sum_valid", 32'(sum_valid), 32'd0);
    step();
    v = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0004, 1'b0};
    run_dot(v, "post-flush");

    // Asynchronous reset mid-accumulation.
    beat(16'h0100, 16'h0100, "rst-accum");
    beat(16'h0000, 16'h0100, "rst-accum");
    prod_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_zero("rst-accum");
    step();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    run_dot(vecs[0], "after rst-accum");

    // Asynchronous reset while a result is held.
    sum_ready = 1'b0;
    beat(16'h0010, 16'h0100, "rst-hold");
    beat(16'h0000, 16'h0100, "rst-hold");
    beat(16'h0000, 16'h0100, "rst-hold");
    prod_valid = 1'b0;
    @(negedge clk);
    check("rst-hold sum_valid before", 32'(sum_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst-hold");
    step();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    run_dot(vecs[7], "after rst-hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
